inst_fetch_responder: RTL and testbench
=======================================

INST_FETCH_RESPONDER -- requirements
Module: inst_fetch_responder

Interface
- REQ-001 The interface SHALL use one clock; reset is asynchronous and active-low.
- REQ-002 Port: clk  in  1  sole clock, rising edge.
- REQ-003 Port: rst  in  1  reset, active-low.
- REQ-004 Port: rdy  in  1  global enable; low holds all state.
- REQ-005 Port: Clear_flag  in  1  pipeline flush; aborts any fetch.
- REQ-006 Port: insqueue_to_memctrl_needchange  in  1  fetch request strobe.
- REQ-007 Port: memctrl_ins_addr_  in  32  fetch byte address.
- REQ-008 Port: memctrl_ins_remain_cycle_  in  4  byte count; only 4 legal.
- REQ-009 Port: data_busy  in  1  load/store path owns RAM this cycle.
- REQ-010 Port: mem_din  in  8  RAM read byte, valid one cycle after address.
- REQ-011 Port: mem_a  out  32  RAM byte address.
- REQ-012 Port: fetch_owns_ram  out  1  mem_a is driven by this block this cycle.
- REQ-013 Port: memctrl_ins_ok  out  1  one-cycle response pulse.
- REQ-014 Port: memctrl_ins_ans  out  32  fetched instruction word.

Function
- REQ-015 States SHALL be IDLE, ISSUE, DRAIN, RESP.
- REQ-016 In IDLE, a high strobe SHALL latch the address, clear the byte counter, and move to ISSUE.
- REQ-017 The responder SHALL ignore strobes in any state other than IDLE.
- REQ-018 In ISSUE with data_busy low, the block SHALL drive mem_a = base+cnt, assert fetch_owns_ram, and increment cnt.
- REQ-019 In ISSUE with data_busy high, the block SHALL issue nothing and hold cnt.
- REQ-020 The byte returned by each issued address SHALL be captured on the next edge, regardless of data_busy.
- REQ-021 Byte k SHALL land in memctrl_ins_ans[8k+7:8k] (little-endian).
- REQ-022 After byte 3 is issued, the block SHALL go to DRAIN, capture byte 3, then go to RESP.
- REQ-023 RESP SHALL assert memctrl_ins_ok for exactly one cycle, hold memctrl_ins_ans stable, and return to IDLE.
- REQ-024 With no stall and no prefetch hit, memctrl_ins_ok SHALL rise on the 5th edge after the accepting edge.
- REQ-025 Each cycle of data_busy SHALL add exactly one cycle of latency.
- REQ-026 memctrl_ins_remain_cycle_ values other than 4 SHALL be treated as 4.
- REQ-027 Address arithmetic SHALL be 32-bit and wrap modulo 2^32.
- REQ-028 Clear_flag SHALL return the block to IDLE on the next edge, suppress memctrl_ins_ok, and discard captured bytes.
- REQ-029 Clear_flag SHALL win over a simultaneous strobe; that strobe is dropped.
- REQ-030 Clear_flag in RESP SHALL still suppress the pulse.
- REQ-031 With rdy low, no state, counter, or output register SHALL change, and fetch_owns_ram SHALL be 0.

Reset
- REQ-032 Asserting rst SHALL, asynchronously, set the state to IDLE and cnt to 0, and zero mem_a, fetch_owns_ram, memctrl_ins_ok and memctrl_ins_ans; it also clears prefetch state.
- REQ-033 Reset asserted mid-fetch SHALL abandon the fetch with no response after release.

Configuration
- REQ-034 Macro INST_PREFETCH_EN: when defined, after each RESP the block SHALL fetch base+4 into a one-entry buffer (valid bit + tag), using idle RAM cycles only.
- REQ-035 With INST_PREFETCH_EN, a strobe whose address equals a valid tag SHALL produce memctrl_ins_ok on the next edge; otherwise the buffer is discarded and a normal fetch starts.
- REQ-036 With INST_PREFETCH_EN, Clear_flag SHALL invalidate the buffer.
- REQ-037 Without INST_PREFETCH_EN, no buffer logic SHALL exist and latency is always per REQ-024.

Structure
- REQ-038 State encodings, the fetch byte count (4) and DATA_WIDTH SHALL live in the shared info header.
- REQ-039 No sub-module is required; the prefetch buffer is inline logic inside the INST_PREFETCH_EN guard.

Verification
- REQ-040 RAM holds bytes 13,05,10,00 at 0x100; strobe at 0x100 -> mem_a 0x100..0x103 on consecutive cycles; ok on 5th edge; ans=0x00100513.
- REQ-041 Same fetch with data_busy high for 2 cycles during ISSUE -> ok on 7th edge; ans unchanged.
- REQ-042 Clear_flag during DRAIN -> no ok pulse; a new strobe at 0x200 is accepted the next cycle.
- REQ-043 rst low during ISSUE, then released -> outputs 0, IDLE, no ok pulse.
- REQ-044 Address 0xFFFFFFFE -> mem_a sequence FFFFFFFE, FFFFFFFF, 0, 1.
- REQ-045 INST_PREFETCH_EN: fetch 0x100, idle 6 cycles, strobe 0x104 -> ok one edge later; strobe 0x300 instead -> normal 5-edge fetch.

Source files
------------

// File: rtl/inst_fetch_responder_pkg.sv
// Shared definitions for the instruction fetch responder: state encodings,
// fetch size and datapath widths.
package inst_fetch_responder_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned FETCH_BYTES = 4;
  localparam int unsigned CNT_WIDTH   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/inst_fetch_responder.sv
// Byte-serial instruction fetch from an 8-bit synchronous RAM into a 32-bit word.
// Optional next-line prefetch buffer enabled by defining INST_PREFETCH_EN.
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  Clear_flag,
  input  logic                  insqueue_to_memctrl_needchange,
  input  logic [ADDR_WIDTH-1:0] memctrl_ins_addr_,
  input  logic [3:0]            memctrl_ins_remain_cycle_,
  input  logic                  data_busy,
  input  logic [7:0]            mem_din,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  fetch_owns_ram,
  output logic                  memctrl_ins_ok,
  output logic [DATA_WIDTH-1:0] memctrl_ins_ans
);

  localparam logic [CNT_WIDTH-1:0] LAST_BYTE = CNT_WIDTH'(FETCH_BYTES - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] base, base_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic                  cap, cap_nxt;
  logic [1:0]            cap_idx, cap_idx_nxt;
  logic [DATA_WIDTH-1:0] ans_nxt;
  logic                  unused_remain;

`ifdef INST_PREFETCH_EN
  logic                  pf_busy, pf_busy_nxt;
  logic                  pf_valid, pf_valid_nxt;
  logic                  pf_cap, pf_cap_nxt;
  logic [1:0]            pf_cap_idx, pf_cap_idx_nxt;
  logic [CNT_WIDTH-1:0]  pf_cnt, pf_cnt_nxt;
  logic [ADDR_WIDTH-1:0] pf_tag, pf_tag_nxt;
  logic [DATA_WIDTH-1:0] pf_data, pf_data_nxt;
`endif

  // Fetch size is fixed at four bytes; the requested count is ignored.
  assign unused_remain = ^memctrl_ins_remain_cycle_;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      base            <= '0;
      cnt             <= '0;
      cap             <= 1'b0;
      cap_idx         <= '0;
      memctrl_ins_ans <= '0;
`ifdef INST_PREFETCH_EN
      pf_busy         <= 1'b0;
      pf_valid        <= 1'b0;
      pf_cap          <= 1'b0;
      pf_cap_idx      <= '0;
      pf_cnt          <= '0;
      pf_tag          <= '0;
      pf_data         <= '0;
`endif
    end else begin
      state           <= state_nxt;
      base            <= base_nxt;
      cnt             <= cnt_nxt;
      cap             <= cap_nxt;
      cap_idx         <= cap_idx_nxt;
      memctrl_ins_ans <= ans_nxt;
`ifdef INST_PREFETCH_EN
      pf_busy         <= pf_busy_nxt;
      pf_valid        <= pf_valid_nxt;
      pf_cap          <= pf_cap_nxt;
      pf_cap_idx      <= pf_cap_idx_nxt;
      pf_cnt          <= pf_cnt_nxt;
      pf_tag          <= pf_tag_nxt;
      pf_data         <= pf_data_nxt;
`endif
    end
  end

  // RAM address and the response pulse depend on same-cycle data_busy/Clear_flag,
  // so they are decoded here from registered state rather than registered.
  always_comb begin
    state_nxt      = state;
    base_nxt       = base;
    cnt_nxt        = cnt;
    cap_nxt        = cap;
    cap_idx_nxt    = cap_idx;
    ans_nxt        = memctrl_ins_ans;
    mem_a          = '0;
    fetch_owns_ram = 1'b0;
    memctrl_ins_ok = 1'b0;
`ifdef INST_PREFETCH_EN
    pf_busy_nxt    = pf_busy;
    pf_valid_nxt   = pf_valid;
    pf_cap_nxt     = pf_cap;
    pf_cap_idx_nxt = pf_cap_idx;
    pf_cnt_nxt     = pf_cnt;
    pf_tag_nxt     = pf_tag;
    pf_data_nxt    = pf_data;
`endif
    if (rdy) begin
      cap_nxt = 1'b0;
`ifdef INST_PREFETCH_EN
      pf_cap_nxt = 1'b0;
`endif
      if (Clear_flag) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        ans_nxt   = '0;
`ifdef INST_PREFETCH_EN
        pf_busy_nxt  = 1'b0;
        pf_valid_nxt = 1'b0;
`endif
      end else begin
        if (cap) ans_nxt[{cap_idx, 3'b000} +: 8] = mem_din;
`ifdef INST_PREFETCH_EN
        if (pf_cap) begin
          pf_data_nxt[{pf_cap_idx, 3'b000} +: 8] = mem_din;
          if (pf_cap_idx == 2'd3) begin
            pf_valid_nxt = 1'b1;
            pf_busy_nxt  = 1'b0;
          end
        end
`endif
        case (state)
          IDLE: begin
            if (insqueue_to_memctrl_needchange) begin
              base_nxt = memctrl_ins_addr_;
              cnt_nxt  = '0;
`ifdef INST_PREFETCH_EN
              pf_busy_nxt  = 1'b0;
              pf_cap_nxt   = 1'b0;
              pf_valid_nxt = 1'b0;
              if (pf_valid && (memctrl_ins_addr_ == pf_tag)) begin
                ans_nxt   = pf_data;
                state_nxt = RESP;
              end else begin
                ans_nxt   = '0;
                state_nxt = ISSUE;
              end
`else
              ans_nxt   = '0;
              state_nxt = ISSUE;
`endif
            end
`ifdef INST_PREFETCH_EN
            else if (pf_busy && !data_busy && (pf_cnt != CNT_WIDTH'(FETCH_BYTES))) begin
              mem_a          = pf_tag + ADDR_WIDTH'(pf_cnt);
              fetch_owns_ram = 1'b1;
              pf_cap_nxt     = 1'b1;
              pf_cap_idx_nxt = pf_cnt[1:0];
              pf_cnt_nxt     = pf_cnt + CNT_WIDTH'(1);
            end
`endif
          end
          ISSUE: begin
            if (!data_busy) begin
              mem_a          = base + ADDR_WIDTH'(cnt);
              fetch_owns_ram = 1'b1;
              cap_nxt        = 1'b1;
              cap_idx_nxt    = cnt[1:0];
              cnt_nxt        = cnt + CNT_WIDTH'(1);
              if (cnt == LAST_BYTE) state_nxt = DRAIN;
            end
          end
          DRAIN: state_nxt = RESP;
          RESP: begin
            memctrl_ins_ok = 1'b1;
            state_nxt      = IDLE;
`ifdef INST_PREFETCH_EN
            pf_tag_nxt   = base + ADDR_WIDTH'(FETCH_BYTES);
            pf_cnt_nxt   = '0;
            pf_busy_nxt  = 1'b1;
            pf_valid_nxt = 1'b0;
`endif
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Self-checking bench for inst_fetch_responder: table of fetch scenarios plus
// hand-written reset/rdy sequences, responses checked through a scoreboard.
module tb_inst_fetch_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        strobe;
  logic [31:0] addr;
  logic [3:0]  remain;
  logic        data_busy;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic        fetch_owns_ram;
  logic        memctrl_ins_ok;
  logic [31:0] memctrl_ins_ans;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] ans;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] addr;
    int          pre_idle;
    int          busy_start;
    int          busy_len;
    int          clr_at;
    bit          noise;
    bit          exp_ok;
    int          exp_lat;
    int          n_iss;
  } vec_t;
  vec_t vecs[12];

`ifdef INST_PREFETCH_EN
  localparam int HIT_LAT = 0;
  localparam int HIT_ISS = 0;
`else
  localparam int HIT_LAT = 5;
  localparam int HIT_ISS = 4;
`endif

  always #5 clk = ~clk;

  inst_fetch_responder dut (
    .clk                            (clk),
    .rst                            (rst),
    .rdy                            (rdy),
    .Clear_flag                     (clear),
    .insqueue_to_memctrl_needchange (strobe),
    .memctrl_ins_addr_              (addr),
    .memctrl_ins_remain_cycle_      (remain),
    .data_busy                      (data_busy),
    .mem_din                        (mem_din),
    .mem_a                          (mem_a),
    .fetch_owns_ram                 (fetch_owns_ram),
    .memctrl_ins_ok                 (memctrl_ins_ok),
    .memctrl_ins_ans                (memctrl_ins_ans)
  );

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'h10;
      32'h103: return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    return {ram_byte(a + 32'd3), ram_byte(a + 32'd2), ram_byte(a + 32'd1), ram_byte(a)};
  endfunction

  // Synchronous RAM: read data appears the cycle after the address; other
  // owners (load/store path) return filler.
  always @(posedge clk) mem_din <= fetch_owns_ram ? ram_byte(mem_a) : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_fetch(input int idx, input vec_t v);
    logic [31:0] iss[$];
    logic [31:0] exp_ans;
    bit          seen;
    seen    = 1'b0;
    exp_ans = '0;
    repeat (v.pre_idle) begin
      @(negedge clk);
      strobe = 1'b0; data_busy = 1'b0; clear = 1'b0;
    end
    @(negedge clk);
    strobe    = 1'b1;
    addr      = v.addr;
    remain    = 4'($urandom_range(0, 15));
    data_busy = 1'b0;
    clear     = 1'b0;
    if (v.exp_ok) sb.push_back('{model_word(v.addr), v.exp_lat});
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      strobe    = v.noise && (k == 2);
      addr      = strobe ? 32'hDEAD0000 : v.addr;
      data_busy = (k >= v.busy_start) && (k < v.busy_start + v.busy_len);
      clear     = (k == v.clr_at);
      #1;
      if (seen) begin
        check($sformatf("v%0d ok_one_cycle", idx), 32'(memctrl_ins_ok), 32'd0);
        check($sformatf("v%0d ans_hold", idx), memctrl_ins_ans, exp_ans);
        break;
      end
      if (fetch_owns_ram) iss.push_back(mem_a);
      if (memctrl_ins_ok) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL v%0d unexpected_ok: got ok with empty scoreboard, want none", idx);
        end else begin
          exp_t e;
          e       = sb.pop_front();
          exp_ans = e.ans;
          check($sformatf("v%0d latency", idx), 32'(k - 1), 32'(e.lat));
          check($sformatf("v%0d ans", idx), memctrl_ins_ans, e.ans);
        end
      end
      @(posedge clk);
      if (clear) break;
    end
    check($sformatf("v%0d ok_seen", idx), 32'(seen), 32'(v.exp_ok));
    if (v.exp_ok) check($sformatf("v%0d n_issue", idx), 32'(iss.size()), 32'(v.n_iss));
    foreach (iss[i]) check($sformatf("v%0d mem_a[%0d]", idx, i), iss[i], v.addr + 32'(i));
  endtask

  initial begin
    bit any_ok;
    //            addr           pre bs bl clr noise ok lat     iss
    vecs[0]  = '{32'h0000_0100, 0, 0, 0, 0, 1'b0, 1'b1, 5,       4};
    vecs[1]  = '{32'h0000_0100, 0, 2, 2, 0, 1'b0, 1'b1, 7,       4};
    vecs[2]  = '{32'h0000_0100, 0, 0, 0, 5, 1'b0, 1'b0, 0,       0};
    vecs[3]  = '{32'h0000_0200, 0, 0, 0, 0, 1'b0, 1'b1, 5,       4};
    vecs[4]  = '{32'hFFFF_FFFE, 0, 0, 0, 0, 1'b0, 1'b1, 5,       4};
    vecs[5]  = '{32'h0000_0300, 0, 1, 1, 0, 1'b1, 1'b1, 6,       4};
    vecs[6]  = '{32'h0000_0400, 0, 0, 0, 6, 1'b0, 1'b0, 0,       0};
    vecs[7]  = '{32'h0000_0500, 2, 4, 3, 0, 1'b0, 1'b1, 8,       4};
    vecs[8]  = '{32'h0000_0100, 0, 0, 0, 0, 1'b0, 1'b1, 5,       4};
    vecs[9]  = '{32'h0000_0104, 6, 0, 0, 0, 1'b0, 1'b1, HIT_LAT, HIT_ISS};
    vecs[10] = '{32'h0000_0300, 0, 0, 0, 0, 1'b0, 1'b1, 5,       4};
    vecs[11] = '{32'h0000_1000, 0, 3, 1, 0, 1'b0, 1'b1, 6,       4};

    rst = 1'b0; rdy = 1'b1; clear = 1'b0; strobe = 1'b0;
    addr = '0; remain = 4'd4; data_busy = 1'b0;
    #1;
    check("rst ok", 32'(memctrl_ins_ok), 32'd0);
    check("rst owns", 32'(fetch_owns_ram), 32'd0);
    check("rst mem_a", mem_a, 32'd0);
    check("rst ans", memctrl_ins_ans, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // rdy low: strobe must not be accepted and RAM must not be claimed
    @(negedge clk);
    rdy = 1'b0; strobe = 1'b1; addr = 32'h100;
    #1 check("rdy_low owns", 32'(fetch_owns_ram), 32'd0);
    @(negedge clk);
    #1 check("rdy_low owns2", 32'(fetch_owns_ram), 32'd0);
    check("rdy_low ok", 32'(memctrl_ins_ok), 32'd0);
    @(negedge clk);
    rdy = 1'b1; strobe = 1'b0;
    @(negedge clk);
    #1 check("rdy_low not_accepted", 32'(fetch_owns_ram), 32'd0);

    for (int i = 0; i < 12; i++) do_fetch(i, vecs[i]);

    // Reset asserted mid-ISSUE abandons the fetch
    @(negedge clk);
    clear = 1'b0; data_busy = 1'b0; strobe = 1'b1; addr = 32'h600;
    @(negedge clk);
    strobe = 1'b0;
    #1 check("pre_rst owns", 32'(fetch_owns_ram), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst owns", 32'(fetch_owns_ram), 32'd0);
    check("midrst mem_a", mem_a, 32'd0);
    check("midrst ans", memctrl_ins_ans, 32'd0);
    check("midrst ok", 32'(memctrl_ins_ok), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    any_ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (memctrl_ins_ok || fetch_owns_ram) any_ok = 1'b1;
    end
    check("post_rst idle", 32'(any_ok), 32'd0);
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
